// File: rtl/axis_byte_packer.sv
// Packs processor byte writes into 16-bit words with a per-packet last flag.
// Words pass through a word FIFO that drives an AXI4-Stream master port.
module axis_byte_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_wr,
  input  logic        i_last,
  input  logic        i_clr_err,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_overflow,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] m_axis_tdata
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    hold_byte_q, hold_byte_d;
  logic          hold_valid_q, hold_valid_d;
  logic          overflow_q, overflow_d;

  logic          push_req;
  logic          push_ok;
  logic          drop;
  logic          pop;
  logic [16:0]   push_word;
  logic [16:0]   rd_entry;

  assign rd_entry      = mem_q[rd_ptr_q];
  assign m_axis_tvalid = (count_q != '0);
  // Data is forced to zero while nothing is buffered so reset shows a clean bus.
  assign m_axis_tdata  = m_axis_tvalid ? rd_entry[15:0] : 16'h0000;
  assign m_axis_tlast  = m_axis_tvalid & rd_entry[16];
  assign o_full        = (count_q == CNT_FULL);
  assign o_empty       = (count_q == '0) & ~hold_valid_q;
  assign o_overflow    = overflow_q;

  always_comb begin
    pop       = m_axis_tvalid & m_axis_tready;
    push_req  = i_wr & (hold_valid_q | i_last);
    push_word = hold_valid_q ? {i_last, i_data, hold_byte_q} : {1'b1, 8'h00, i_data};
    // A full FIFO still takes a word when the head leaves in the same cycle.
    push_ok   = push_req & ((count_q != CNT_FULL) | pop);
    drop      = push_req & ~push_ok;

    hold_byte_d  = hold_byte_q;
    hold_valid_d = hold_valid_q;
    if (i_wr) begin
      if (hold_valid_q) begin
        hold_valid_d = 1'b0;
      end else if (!i_last) begin
        hold_byte_d  = i_data;
        hold_valid_d = 1'b1;
      end
    end

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (i_clr_err) begin
      overflow_d = 1'b0;
    end

    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_byte_q  <= 8'h00;
      hold_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_byte_q  <= hold_byte_d;
      hold_valid_q <= hold_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge i_clk) begin
    if (push_ok && !i_rst) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed bench for axis_byte_packer: packing, FIFO full/overflow,
// concurrent push/pop at full, mid-packet reset and overflow clearing.
module tb_axis_byte_packer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_wr;
  logic        i_last;
  logic        i_clr_err;
  logic        o_full;
  logic        o_empty;
  logic        o_overflow;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] m_axis_tdata;

  int checks = 0;
  int errors = 0;

  axis_byte_packer #(.FIFO_DEPTH(16)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .i_wr          (i_wr),
    .i_last        (i_last),
    .i_clr_err     (i_clr_err),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_overflow    (o_overflow),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change 1 ns after a rising edge and are held through the next one.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic last);
    i_wr = 1'b1;
    i_data = d;
    i_last = last;
    tick();
    i_wr = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++;
    if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
    checks++;
    if (m_axis_tdata !== 16'h0000) begin errors++; $display("FAIL reset_tdata: got %h expected 0000", m_axis_tdata); end
    checks++;
    if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", o_full); end
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
    $display("reset: tvalid=%b empty=%b full=%b overflow=%b", m_axis_tvalid, o_empty, o_full, o_overflow);
  endtask

  task automatic test_even_packet();
    m_axis_tready = 1'b0;
    wr(8'h34, 1'b0);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL even_half_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++;
    if (o_empty !== 1'b0) begin errors++; $display("FAIL even_half_empty: got %b expected 0", o_empty); end
    wr(8'h12, 1'b1);
    checks++;
    if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL even_tvalid: got %b expected 1", m_axis_tvalid); end
    checks++;
    if (m_axis_tdata !== 16'h1234) begin errors++; $display("FAIL even_tdata: got %h expected 1234", m_axis_tdata); end
    checks++;
    if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL even_tlast: got %b expected 1", m_axis_tlast); end
    $display("even: beat tdata=%h tlast=%b", m_axis_tdata, m_axis_tlast);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL even_empty_after: got %b expected 1", o_empty); end
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL even_tvalid_after: got %b expected 0", m_axis_tvalid); end
  endtask

  task automatic test_odd_packet();
    m_axis_tready = 1'b0;
    wr(8'hAA, 1'b0);
    wr(8'hBB, 1'b0);
    wr(8'hCC, 1'b1);
    checks++;
    if (m_axis_tdata !== 16'hBBAA) begin errors++; $display("FAIL odd_beat0_tdata: got %h expected bbaa", m_axis_tdata); end
    checks++;
    if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL odd_beat0_tlast: got %b expected 0", m_axis_tlast); end
    $display("odd: beat0 tdata=%h tlast=%b", m_axis_tdata, m_axis_tlast);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    checks++;
    if (m_axis_tdata !== 16'h00CC) begin errors++; $display("FAIL odd_beat1_tdata: got %h expected 00cc", m_axis_tdata); end
    checks++;
    if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL odd_beat1_tlast: got %b expected 1", m_axis_tlast); end
    $display("odd: beat1 tdata=%h tlast=%b", m_axis_tdata, m_axis_tlast);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL odd_empty_after: got %b expected 1", o_empty); end
  endtask

  task automatic test_full_overflow();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(8'(i), 1'b0);
      wr(8'h00, 1'b0);
    end
    checks++;
    if (o_full !== 1'b1) begin errors++; $display("FAIL full_set: got %b expected 1", o_full); end
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow: got %b expected 0", o_overflow); end
    wr(8'h55, 1'b0);
    wr(8'h66, 1'b0);
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", o_overflow); end
    checks++;
    if (o_empty !== 1'b0) begin errors++; $display("FAIL overflow_empty: got %b expected 0", o_empty); end
    $display("full: full=%b overflow=%b", o_full, o_overflow);
    tick();
    tick();
    checks++;
    if (m_axis_tdata !== 16'h0000 || m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL stall_stable: got %h/%b expected 0000/1", m_axis_tdata, m_axis_tvalid);
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(i)) begin
        errors++; $display("FAIL drain_beat%0d: got %h/%b expected %h/1", i, m_axis_tdata, m_axis_tvalid, 16'(i));
      end
      $display("drain: beat %0d tdata=%h", i, m_axis_tdata);
      tick();
    end
    m_axis_tready = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || o_empty !== 1'b1) begin
      errors++; $display("FAIL drain_done: got tvalid=%b empty=%b expected 0/1", m_axis_tvalid, o_empty);
    end
  endtask

  task automatic test_overflow_clear();
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b expected 0", o_overflow); end
    $display("clear: overflow=%b", o_overflow);
  endtask

  task automatic test_full_concurrent_pop();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(8'(i), 1'b0);
      wr(8'h01, 1'b0);
    end
    checks++;
    if (o_full !== 1'b1) begin errors++; $display("FAIL cpop_full_before: got %b expected 1", o_full); end
    wr(8'h77, 1'b0);
    m_axis_tready = 1'b1;
    wr(8'h88, 1'b1);
    m_axis_tready = 1'b0;
    checks++;
    if (o_full !== 1'b1) begin errors++; $display("FAIL cpop_full_after: got %b expected 1", o_full); end
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL cpop_no_overflow: got %b expected 0", o_overflow); end
    checks++;
    if (m_axis_tdata !== 16'h0101) begin errors++; $display("FAIL cpop_head: got %h expected 0101", m_axis_tdata); end
    $display("concurrent: full=%b overflow=%b head=%h", o_full, o_overflow, m_axis_tdata);
    // Clear arriving in the same cycle as a drop must lose to the drop.
    wr(8'h99, 1'b0);
    i_clr_err = 1'b1;
    wr(8'hAA, 1'b0);
    i_clr_err = 1'b0;
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_drop: got %b expected 1", o_overflow); end
    $display("clear+drop: overflow=%b", o_overflow);
    test_overflow_clear();
    m_axis_tready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      logic [15:0] exp_data;
      logic        exp_last;
      exp_data = (i == 16) ? 16'h8877 : (16'h0100 + 16'(i));
      exp_last = (i == 16);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_data || m_axis_tlast !== exp_last) begin
        errors++; $display("FAIL wrap_beat%0d: got %h/%b expected %h/%b", i, m_axis_tdata, m_axis_tlast, exp_data, exp_last);
      end
      $display("wrap drain: beat %0d tdata=%h tlast=%b", i, m_axis_tdata, m_axis_tlast);
      tick();
    end
    m_axis_tready = 1'b0;
    checks++;
    if (o_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", o_empty); end
  endtask

  task automatic test_reset_mid_packet();
    m_axis_tready = 1'b0;
    wr(8'h11, 1'b0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checks++;
    if (o_empty !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_cleared: got empty=%b tvalid=%b expected 1/0", o_empty, m_axis_tvalid);
    end
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b1);
    checks++;
    if (m_axis_tdata !== 16'h3322 || m_axis_tlast !== 1'b1) begin
      errors++; $display("FAIL midrst_beat: got %h/%b expected 3322/1", m_axis_tdata, m_axis_tlast);
    end
    $display("mid-reset: beat tdata=%h tlast=%b", m_axis_tdata, m_axis_tlast);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    checks++;
    if (o_empty !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_single: got empty=%b tvalid=%b expected 1/0", o_empty, m_axis_tvalid);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_data = 8'h00;
    i_wr = 1'b0;
    i_last = 1'b0;
    i_clr_err = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    test_reset();
    test_even_packet();
    test_odd_packet();
    test_full_overflow();
    test_overflow_clear();
    test_full_concurrent_pop();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
